// File: rtl/cnn_sched_pkg.sv
// rtl/cnn_sched_pkg.sv - shared types, constants and pixel conversion for cnn_frame_sched
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    START,
    WAIT,
    DONE
  } sched_state_t;

  localparam logic [3:0] DIGIT_TIMEOUT = 4'hF;

  // Unweighted channel sum scaled by 3 so that full white (7+7+7) lands exactly on 63.
  function automatic logic [5:0] rgb333_to_gray6(input logic [8:0] rgb);
    logic [5:0] sum;
    sum = 6'(rgb[8:6]) + 6'(rgb[5:3]) + 6'(rgb[2:0]);
    return sum * 6'd3;
  endfunction

endpackage

// File: rtl/cnn_rd_pipe.sv
// rtl/cnn_rd_pipe.sv - RD_LAT-deep valid/index delay line aligning pixel writes with BRAM read data
module cnn_rd_pipe #(
  parameter int LAT   = 1,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [LAT-1:0]   vld;
  logic [IDX_W-1:0] idx [0:LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int s = 0; s < LAT; s++) idx[s] <= '0;
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int s = 1; s < LAT; s++) begin
        vld[s] <= vld[s-1];
        idx[s] <= idx[s-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_idx   = idx[LAT-1];

endmodule

// File: rtl/cnn_frame_sched.sv
// rtl/cnn_frame_sched.sv - fetches a 28x28 RGB333 region into a gray buffer and sequences digit_cnn
// Optional CNN_SCHED_PERF_EN adds perf_cyc, the WAIT-cycle count of the last inference.
module cnn_frame_sched
  import cnn_sched_pkg::*;
#(
  parameter int NPIX        = 784,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 17,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_rdy,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [8:0]        bram_dout,
  output logic [5:0]        pixels [0:NPIX-1],
  output logic              cnn_start,
  input  logic              cnn_valid,
  input  logic [3:0]        cnn_digit,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_digit,
  output logic              res_err,
  output logic              busy,
`ifdef CNN_SCHED_PERF_EN
  output logic [31:0]       perf_cyc,
`endif
  output logic [7:0]        drop_cnt
);

  localparam int IDX_W = $clog2(NPIX);

  sched_state_t     state, state_nx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] fetch_idx;
  logic [1:0]       drain_cnt;
  logic [31:0]      wait_cnt;
  logic             tmo_hit;
  logic             wr_valid;
  logic [IDX_W-1:0] wr_idx;

  assign cnn_start = (state == START);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // wait_cnt counts WAIT cycles including the current one, i.e. cycles since cnn_start.
  assign tmo_hit   = (wait_cnt == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_rdy) state_nx = FETCH;
      FETCH:   if (rd_idx == IDX_W'(NPIX - 1)) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'(RD_LAT)) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (cnn_valid || tmo_hit) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx    <= '0;
      fetch_idx <= '0;
      bram_en   <= 1'b0;
      bram_addr <= ADDR_W'(BASE_ADDR);
      drain_cnt <= '0;
      wait_cnt  <= '0;
      res_digit <= '0;
      res_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      bram_en <= (state == FETCH);
      if (state == FETCH) begin
        bram_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx);
        fetch_idx <= rd_idx;
        rd_idx    <= rd_idx + IDX_W'(1);
      end else if (state == IDLE) begin
        rd_idx <= '0;
      end
      // The last read is issued one cycle into DRAIN, so DRAIN spans RD_LAT+1 cycles.
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == START)     wait_cnt <= 32'd1;
      else if (state == WAIT) wait_cnt <= wait_cnt + 32'd1;
      if (state == WAIT) begin
        if (cnn_valid) begin
          res_digit <= cnn_digit;
          res_err   <= 1'b0;
        end else if (tmo_hit) begin
          res_digit <= DIGIT_TIMEOUT;
          res_err   <= 1'b1;
        end
      end
      if (frame_rdy && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef CNN_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              perf_cyc <= '0;
    else if (state == WAIT && state_nx == DONE) perf_cyc <= wait_cnt;
  end
`endif

  cnn_rd_pipe #(
    .LAT   (RD_LAT),
    .IDX_W (IDX_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bram_en),
    .in_idx    (fetch_idx),
    .out_valid (wr_valid),
    .out_idx   (wr_idx)
  );

  // Writes are confined to FETCH/DRAIN so the buffer is frozen while digit_cnn runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPIX; k++) pixels[k] <= '0;
    end else if (wr_valid && (state == FETCH || state == DRAIN)) begin
      pixels[wr_idx] <= rgb333_to_gray6(bram_dout);
    end
  end

endmodule

// File: tb/tb_cnn_frame_sched.sv
// tb/tb_cnn_frame_sched.sv - randomized self-checking bench for cnn_frame_sched (RD_LAT=1 and RD_LAT=3 instances)
module tb_cnn_frame_sched;

  localparam int NPIX   = 784;
  localparam int TMO_A  = 1000;
  localparam int TMO_B  = 100;
  localparam int BASE_B = 16;

  logic clk = 1'b0;
  logic rst_n, sel, fr, cv, rr;
  logic [3:0] dig;

  logic [16:0] bram_addr_a, bram_addr_b;
  logic        bram_en_a, bram_en_b;
  logic [8:0]  dout_a, dout_b, b_d1, b_d2;
  logic [5:0]  pix_a [0:NPIX-1];
  logic [5:0]  pix_b [0:NPIX-1];
  logic        start_a, start_b, rv_a, rv_b, err_a, err_b, busy_a, busy_b;
  logic [3:0]  rd_a, rd_b;
  logic [7:0]  drop_a, drop_b;
  logic [31:0] perf_a, perf_b;

  logic [8:0] mem [0:1023];
  int exp_pix [0:NPIX-1];
  int drops_exp [0:1];
  int starts [0:1];
  int n_cmp = 0;
  int n_mis = 0;

  wire frame_rdy_a = fr & ~sel;
  wire frame_rdy_b = fr & sel;
  wire valid_a     = cv & ~sel;
  wire valid_b     = cv & sel;
  wire ready_a     = rr & ~sel;
  wire ready_b     = rr & sel;

  wire        cur_start = sel ? start_b : start_a;
  wire        cur_rv    = sel ? rv_b : rv_a;
  wire        cur_err   = sel ? err_b : err_a;
  wire        cur_busy  = sel ? busy_b : busy_a;
  wire        cur_en    = sel ? bram_en_b : bram_en_a;
  wire [16:0] cur_addr  = sel ? bram_addr_b : bram_addr_a;
  wire [3:0]  cur_dig   = sel ? rd_b : rd_a;
  wire [7:0]  cur_drop  = sel ? drop_b : drop_a;
  wire [31:0] cur_perf  = sel ? perf_b : perf_a;

  cnn_frame_sched #(.NPIX(NPIX), .BASE_ADDR(0), .ADDR_W(17), .RD_LAT(1), .TIMEOUT_CYC(TMO_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .frame_rdy(frame_rdy_a), .bram_addr(bram_addr_a), .bram_en(bram_en_a),
    .bram_dout(dout_a), .pixels(pix_a), .cnn_start(start_a), .cnn_valid(valid_a), .cnn_digit(dig),
    .res_valid(rv_a), .res_ready(ready_a), .res_digit(rd_a), .res_err(err_a), .busy(busy_a),
`ifdef CNN_SCHED_PERF_EN
    .perf_cyc(perf_a),
`endif
    .drop_cnt(drop_a)
  );

  cnn_frame_sched #(.NPIX(NPIX), .BASE_ADDR(BASE_B), .ADDR_W(17), .RD_LAT(3), .TIMEOUT_CYC(TMO_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .frame_rdy(frame_rdy_b), .bram_addr(bram_addr_b), .bram_en(bram_en_b),
    .bram_dout(dout_b), .pixels(pix_b), .cnn_start(start_b), .cnn_valid(valid_b), .cnn_digit(dig),
    .res_valid(rv_b), .res_ready(ready_b), .res_digit(rd_b), .res_err(err_b), .busy(busy_b),
`ifdef CNN_SCHED_PERF_EN
    .perf_cyc(perf_b),
`endif
    .drop_cnt(drop_b)
  );

`ifndef CNN_SCHED_PERF_EN
  assign perf_a = '0;
  assign perf_b = '0;
`endif

  always #5 clk = ~clk;

  // BRAM models: 1-cycle and 3-cycle read latency, output held while not enabled.
  always @(posedge clk) begin
    if (bram_en_a) dout_a <= mem[bram_addr_a[9:0]];
    if (bram_en_b) b_d1 <= mem[bram_addr_b[9:0]];
    b_d2   <= b_d1;
    dout_b <= b_d2;
  end

  always @(negedge clk) begin
    if (start_a) starts[0]++;
    if (start_b) starts[1]++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_gray(input int w);
    return (((w >> 6) & 7) + ((w >> 3) & 7) + (w & 7)) * 3;
  endfunction

  function automatic int get_pix(input int k);
    return sel ? int'(pix_b[k]) : int'(pix_a[k]);
  endfunction

  function automatic int pix_err();
    int e = 0;
    for (int k = 0; k < NPIX; k++) if (get_pix(k) != exp_pix[k]) e++;
    return e;
  endfunction

  function automatic int pix_nz();
    int e = 0;
    for (int k = 0; k < NPIX; k++) if (get_pix(k) != 0) e++;
    return e;
  endfunction

  task automatic bump_drop(input bit s);
    if (drops_exp[s] < 255) drops_exp[s]++;
  endtask

  // One full frame: fetch, inference wait, result hold and handshake.
  task automatic run(input bit s, input bit patt, input int vdel, input logic [3:0] digit,
                     input int rdel, input int nfd, input bit hs_drop);
    int lat, tmo, base, n, m, done_at, st0, w;
    logic [3:0] ed;
    logic ee;
    lat  = s ? 3 : 1;
    tmo  = s ? TMO_B : TMO_A;
    base = s ? BASE_B : 0;
    sel  = s;
    for (int k = 0; k < NPIX; k++) begin
      w = patt ? (k % 8) * 73 : int'($urandom_range(0, 511));
      mem[base + k] = 9'(w);
      exp_pix[k] = ref_gray(w);
    end
    if (vdel >= 1 && vdel < tmo) begin
      done_at = vdel + 1; ed = digit; ee = 1'b0;
    end else begin
      done_at = tmo; ed = 4'hF; ee = 1'b1;
    end
    st0 = starts[s];
    @(negedge clk); fr = 1'b1;
    @(negedge clk); fr = 1'b0; n = 1;
    @(negedge clk); n = 2;
    check_eq("fetch_en", int'(cur_en), 1);
    check_eq("fetch_addr", int'(cur_addr), base);
    check_eq("fetch_busy", int'(cur_busy), 1);
    for (int j = 0; j < nfd; j++) begin
      fr = 1'b1; bump_drop(s);
      @(negedge clk); fr = 1'b0;
      @(negedge clk); n += 2;
    end
    while (!cur_start && n < 3000) begin
      @(negedge clk); n++;
    end
    check_eq("start_lat", n, NPIX + lat + 2);
    check_eq("pix_fetch_errs", pix_err(), 0);
    if (patt) begin
      check_eq("pix7", get_pix(7), 63);
      check_eq("pix9", get_pix(9), 9);
    end
    m = 0;
    while (m < tmo + 10) begin
      @(negedge clk); m++;
      if (cur_rv) break;
      fr = (m == 2);
      if (m == 2) bump_drop(s);
      cv  = (m == vdel);
      dig = digit;
    end
    cv = 1'b0; fr = 1'b0;
    check_eq("done_lat", m, done_at);
    check_eq("pix_hold_errs", pix_err(), 0);
    for (int r = 0; r < rdel; r++) begin
      check_eq("hold_valid", int'(cur_rv), 1);
      check_eq("hold_digit", int'(cur_dig), int'(ed));
      check_eq("hold_err", int'(cur_err), int'(ee));
      @(negedge clk);
    end
    check_eq("res_digit", int'(cur_dig), int'(ed));
    check_eq("res_err", int'(cur_err), int'(ee));
    rr = 1'b1; fr = hs_drop;
    if (hs_drop) bump_drop(s);
    @(negedge clk); rr = 1'b0; fr = 1'b0;
    check_eq("idle_valid", int'(cur_rv), 0);
    check_eq("idle_busy", int'(cur_busy), 0);
    check_eq("drop_cnt", int'(cur_drop), drops_exp[s]);
    check_eq("start_count", starts[s] - st0, 1);
`ifdef CNN_SCHED_PERF_EN
    check_eq("perf_cyc", int'(cur_perf), done_at - 1);
`endif
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; fr = 1'b0; cv = 1'b0; rr = 1'b0; dig = 4'd0;
    drops_exp[0] = 0; drops_exp[1] = 0;
    starts[0] = 0; starts[1] = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_en", int'(bram_en_a), 0);
    check_eq("rst_addr_b", int'(bram_addr_b), BASE_B);
    check_eq("rst_start", int'(start_a), 0);
    check_eq("rst_valid", int'(rv_a), 0);
    check_eq("rst_busy", int'(busy_a), 0);
    check_eq("rst_drop", int'(drop_a), 0);
    check_eq("rst_digit", int'(rd_a), 0);
    check_eq("rst_err", int'(err_a), 0);
    check_eq("rst_pix_nz", pix_nz(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 1'b1, 500, 4'd7, 10, 1, 1'b1);
    run(1'b0, 1'b0, TMO_A - 1, 4'($urandom_range(0, 9)), 0, 0, 1'b0);
    run(1'b1, 1'b1, -1, 4'd0, 3, 0, 1'b0);
    run(1'b1, 1'b0, TMO_B - 1, 4'($urandom_range(0, 9)), 1, 2, 1'b0);
    run(1'b0, 1'b0, int'($urandom_range(3, 900)), 4'($urandom_range(0, 9)),
        int'($urandom_range(0, 5)), 300, 1'b0);

    sel = 1'b0;
    for (int k = 0; k < NPIX; k++) mem[k] = 9'($urandom_range(1, 511));
    @(negedge clk); fr = 1'b1;
    @(negedge clk); fr = 1'b0;
    repeat (400) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", int'(busy_a), 0);
    check_eq("mrst_en", int'(bram_en_a), 0);
    check_eq("mrst_addr", int'(bram_addr_a), 0);
    check_eq("mrst_drop", int'(drop_a), 0);
    check_eq("mrst_digit", int'(rd_a), 0);
    check_eq("mrst_pix_nz", pix_nz(), 0);
    drops_exp[0] = 0; drops_exp[1] = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_eq("mrst_valid", int'(rv_a), 0);

    run(1'b0, 1'b0, int'($urandom_range(3, 900)), 4'($urandom_range(0, 9)),
        int'($urandom_range(0, 5)), 0, 1'b1);
    run(1'b1, 1'b0, int'($urandom_range(3, 90)), 4'($urandom_range(0, 9)),
        int'($urandom_range(0, 5)), 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
